vga_fb_arbiter: RTL and testbench



---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_fetch_sched.sv | 31 +++
 rtl/vga_fb_arbiter.sv | 104 ++++++++++
 tb/tb_vga_fb_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing, framebuffer geometry and pixel bit positions for the
// scanout fetch scheduler and the framebuffer arbiter.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_SIZE  = FB_W * FB_H;
    localparam int ADDR_W   = 15;

    localparam int PIX_R1 = 5;
    localparam int PIX_R0 = 4;
    localparam int PIX_G1 = 3;
    localparam int PIX_G0 = 2;
    localparam int PIX_B1 = 1;
    localparam int PIX_B0 = 0;

    function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
        return ADDR_W'(row) * ADDR_W'(FB_W) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/vga_fetch_sched.sv
// Scanout slot decoder: maps the vga_sync counters to the framebuffer
// row/column that must be read this cycle, if any.
module vga_fetch_sched
    import vga_pkg::*;
(
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    output logic       slot,
    output logic [6:0] row,
    output logic [7:0] col
);

    logic [10:0] line;

    always_comb begin
        slot = 1'b0;
        line = 11'd0;
        col  = 8'd0;
        // Group 0 of the next line is prefetched in the horizontal blank.
        if (h_count == 10'(H_TOTAL - 2)) begin
            line = (v_count == 10'(V_TOTAL - 1)) ? 11'd0 : {1'b0, v_count} + 11'd1;
            slot = (line < 11'(V_ACTIVE));
        end else if (h_count >= 10'd2 && h_count <= 10'(H_ACTIVE - 6) && h_count[1:0] == 2'b10) begin
            line = {1'b0, v_count};
            col  = 8'((h_count + 10'd2) >> 2);
            slot = (line < 11'(V_ACTIVE));
        end
        row = slot ? line[8:2] : 7'd0;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads win, writer gets the rest.
// Define VGA_FB_STATS_EN to add the stall_count writer-stall counter.
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic              clk_in,
    input  logic              reset,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              display_en,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [5:0]        wr_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [5:0]        ram_wdata,
    input  logic [5:0]        ram_rdata,
    output logic              r0,
    output logic              r1,
    output logic              g0,
    output logic              g1,
    output logic              b0,
    output logic              b1
`ifdef VGA_FB_STATS_EN
    ,
    output logic [15:0]       stall_count
`endif
);

    logic       slot;
    logic [6:0] slot_row;
    logic [7:0] slot_col;
    logic       wr_in_range;
    logic       rd_pend;
    logic [5:0] pix;
    logic [5:0] colour;

    vga_fetch_sched u_sched (
        .h_count (h_count),
        .v_count (v_count),
        .slot    (slot),
        .row     (slot_row),
        .col     (slot_col)
    );

    assign wr_in_range = (wr_addr < ADDR_W'(FB_SIZE));

    always_comb begin
        wr_ready  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 6'd0;
        if (reset) begin
            if (slot) begin
                ram_en   = 1'b1;
                ram_addr = fb_addr(slot_row, slot_col);
            end else begin
                wr_ready = 1'b1;
                // Out-of-range writes are acknowledged but never reach the RAM.
                if (wr_valid && wr_in_range) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = wr_addr;
                    ram_wdata = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            rd_pend <= 1'b0;
            pix     <= 6'd0;
            colour  <= 6'd0;
        end else begin
            rd_pend <= slot;
            if (rd_pend) begin
                pix <= ram_rdata;
            end
            colour <= display_en ? pix : 6'd0;
        end
    end

    assign r1 = colour[PIX_R1];
    assign r0 = colour[PIX_R0];
    assign g1 = colour[PIX_G1];
    assign g0 = colour[PIX_G0];
    assign b1 = colour[PIX_B1];
    assign b0 = colour[PIX_B0];

`ifdef VGA_FB_STATS_EN
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            stall_count <= 16'd0;
        end else if (wr_valid && !wr_ready && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed counter vectors, a
// spec-level model of slots/writes/colour checked every cycle, literal pins.
module tb_vga_fb_arbiter;
    import vga_pkg::*;

    logic              clk_in;
    logic              reset;
    logic [9:0]        h_count;
    logic [9:0]        v_count;
    logic              display_en;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [5:0]        wr_data;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [5:0]        ram_wdata;
    logic [5:0]        ram_rdata;
    logic              r0, r1, g0, g1, b0, b1;
`ifdef VGA_FB_STATS_EN
    logic [15:0]       stall_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit frame_chk = 1'b0;

    bit prev_rst   = 1'b0;
    bit prev_de    = 1'b0;
    bit prev_frame = 1'b0;
    int prev_h     = 0;
    int prev_v     = 0;

    vga_fb_arbiter dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .h_count    (h_count),
        .v_count    (v_count),
        .display_en (display_en),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .r0         (r0),
        .r1         (r1),
        .g0         (g0),
        .g1         (g1),
        .b0         (b0),
        .b1         (b1)
`ifdef VGA_FB_STATS_EN
        ,
        .stall_count(stall_count)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // RAM model whose contents are mem[a] = a[5:0]; one-cycle read latency.
    always @(posedge clk_in) begin
        if (ram_en && !ram_we) ram_rdata <= ram_addr[5:0];
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (h=%0d v=%0d)", name, act, exp, h_count, v_count);
        end
    endtask

    // Address of the scanout read owed at (h, v), or -1 when no read is due.
    function automatic int model_slot_addr(input int h, input int v);
        int line;
        int k;
        if (h == H_TOTAL - 2) begin
            line = (v == V_TOTAL - 1) ? 0 : v + 1;
            k = 0;
        end else if (h >= 2 && h <= H_ACTIVE - 6 && h % 4 == 2) begin
            line = v;
            k = (h + 2) / 4;
        end else begin
            return -1;
        end
        if (line >= V_ACTIVE) return -1;
        return (line / 4) * FB_W + k;
    endfunction

    function automatic int colour_now();
        return int'({r1, r0, g1, g0, b1, b0});
    endfunction

    always @(negedge clk_in) begin
        int sa;
        if (!reset) begin
            chk("rst_wr_ready", int'(wr_ready), 0);
            chk("rst_ram_en", int'(ram_en), 0);
        end else begin
            sa = model_slot_addr(int'(h_count), int'(v_count));
            if (sa >= 0) begin
                chk("slot_wr_ready", int'(wr_ready), 0);
                chk("slot_ram_en", int'(ram_en), 1);
                chk("slot_ram_we", int'(ram_we), 0);
                chk("slot_ram_addr", int'(ram_addr), sa);
            end else begin
                chk("free_wr_ready", int'(wr_ready), 1);
                if (wr_valid && int'(wr_addr) < FB_SIZE) begin
                    chk("wr_ram_en", int'(ram_en), 1);
                    chk("wr_ram_we", int'(ram_we), 1);
                    chk("wr_ram_addr", int'(ram_addr), int'(wr_addr));
                    chk("wr_ram_wdata", int'(ram_wdata), int'(wr_data));
                end else begin
                    chk("idle_ram_en", int'(ram_en), 0);
                    chk("idle_ram_we", int'(ram_we), 0);
                    chk("idle_ram_addr", int'(ram_addr), 0);
                    chk("idle_ram_wdata", int'(ram_wdata), 0);
                end
            end
        end
        if (!prev_rst || !prev_de)
            chk("colour_blank", colour_now(), 0);
        else if (prev_frame)
            chk("colour_pix", colour_now(), ((prev_v / 4) * FB_W + prev_h / 4) % 64);
        prev_rst   = reset;
        prev_de    = display_en;
        prev_frame = frame_chk;
        prev_h     = int'(h_count);
        prev_v     = int'(v_count);
    end

    task automatic step(input int h, input int v);
        @(posedge clk_in);
        #1;
        h_count    = 10'(h);
        v_count    = 10'(v);
        display_en = (h < H_ACTIVE) && (v < V_ACTIVE);
    endtask

    task automatic run_seg(input int pre_v, input int first_v, input int nlines);
        for (int h = H_TOTAL - 10; h < H_TOTAL; h++) begin
            step(h, pre_v);
            frame_chk = 1'b1;
        end
        for (int l = 0; l < nlines; l++) begin
            for (int h = 0; h < H_TOTAL; h++) begin
                step(h, first_v + l);
                if (first_v + l == 5 && h == 41) begin
                    @(negedge clk_in);
                    chk("lit_colour_v5_h41", colour_now(), 42);
                end
                if (first_v + l == 478 && h == 5) begin
                    @(negedge clk_in);
                    chk("lit_colour_v478_h5", colour_now(), 33);
                end
                if (first_v + l == 479 && h == 640) begin
                    @(negedge clk_in);
                    chk("lit_colour_v479_h640", colour_now(), 63);
                end
            end
        end
        frame_chk = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        h_count    = 10'd100;
        v_count    = 10'd0;
        display_en = 1'b1;
        wr_valid   = 1'b1;
        wr_addr    = 15'd5;
        wr_data    = 6'd1;

        // Reset held with a pending write request.
        step(100, 0);
        step(100, 0);
        step(100, 0);
        @(negedge clk_in);
        chk("lit_rst_wr_ready", int'(wr_ready), 0);
        chk("lit_rst_ram_en", int'(ram_en), 0);
        chk("lit_rst_colour", colour_now(), 0);

        step(100, 0);
        reset    = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 15'd0;
        wr_data  = 6'h3F;
        @(negedge clk_in);
        chk("lit_wr_ready", int'(wr_ready), 1);
        chk("lit_wr_en", int'(ram_en), 1);
        chk("lit_wr_we", int'(ram_we), 1);
        chk("lit_wr_addr", int'(ram_addr), 0);
        chk("lit_wr_wdata", int'(ram_wdata), 63);

        // Write held across a scanout slot.
        step(6, 0);
        wr_addr = 15'd321;
        wr_data = 6'h15;
        @(negedge clk_in);
        chk("lit_blk_wr_ready", int'(wr_ready), 0);
        chk("lit_blk_we", int'(ram_we), 0);
        chk("lit_blk_addr", int'(ram_addr), 2);
        step(7, 0);
        @(negedge clk_in);
        chk("lit_acc_wr_ready", int'(wr_ready), 1);
        chk("lit_acc_we", int'(ram_we), 1);
        chk("lit_acc_addr", int'(ram_addr), 321);

        // Next-line prefetch in horizontal blank.
        step(798, 3);
        wr_valid = 1'b0;
        @(negedge clk_in);
        chk("lit_pf_v3_en", int'(ram_en), 1);
        chk("lit_pf_v3_addr", int'(ram_addr), 160);
        step(798, 524);
        @(negedge clk_in);
        chk("lit_pf_v524_addr", int'(ram_addr), 0);
        step(798, 479);
        @(negedge clk_in);
        chk("lit_pf_v479_en", int'(ram_en), 0);
        chk("lit_pf_v479_ready", int'(wr_ready), 1);

        // Out-of-range write is accepted and dropped; out-of-range counters.
        step(101, 0);
        wr_valid = 1'b1;
        wr_addr  = 15'd19200;
        wr_data  = 6'h2A;
        @(negedge clk_in);
        chk("lit_oor_ready", int'(wr_ready), 1);
        chk("lit_oor_en", int'(ram_en), 0);
        step(900, 10);
        wr_addr = 15'd7;
        @(negedge clk_in);
        chk("lit_hoor_ready", int'(wr_ready), 1);
        step(902, 10);
        wr_valid = 1'b0;

        // Scanout over the top and bottom of the frame.
        run_seg(524, 0, 6);
        run_seg(474, 475, 7);

`ifdef VGA_FB_STATS_EN
        step(100, 0);
        reset = 1'b0;
        step(100, 0);
        reset    = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 15'd9;
        wr_data  = 6'd3;
        for (int i = 0; i < 5; i++) step(2 + 4 * i, 0);
        step(19, 0);
        wr_valid = 1'b0;
        @(negedge clk_in);
        chk("lit_stall_count", int'(stall_count), 5);
`endif

        step(100, 0);
        step(100, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
